// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit:
// funct3 codes, FSM state encoding and a legality helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_e;

  // Stores only exist for b/h/w/d; loads lack a 111 form.
  function automatic logic f3_illegal(
    input logic       wr,
    input logic [2:0] f3
  );
    return wr ? f3[2] : (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load-data extension and store-data byte merge
// for the doubleword-wide data memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [63:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] ext_o,
  output logic [63:0] merged_o
);

  always_comb begin
    ext_o = rdata_i;
    case (funct3_i)
      F3_B:    ext_o = {{56{rdata_i[7]}}, rdata_i[7:0]};
      F3_H:    ext_o = {{48{rdata_i[15]}}, rdata_i[15:0]};
      F3_W:    ext_o = {{32{rdata_i[31]}}, rdata_i[31:0]};
      F3_D:    ext_o = rdata_i;
      F3_BU:   ext_o = {56'd0, rdata_i[7:0]};
      F3_HU:   ext_o = {48'd0, rdata_i[15:0]};
      F3_WU:   ext_o = {32'd0, rdata_i[31:0]};
      default: ext_o = rdata_i;
    endcase
  end

  // Only sub-doubleword stores go through the merge path.
  always_comb begin
    merged_o = rdata_i;
    case (funct3_i[1:0])
      2'b00:   merged_o = {rdata_i[63:8], wdata_i[7:0]};
      2'b01:   merged_o = {rdata_i[63:16], wdata_i[15:0]};
      2'b10:   merged_o = {rdata_i[63:32], wdata_i[31:0]};
      default: merged_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time,
// sub-doubleword stores done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 101
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [63:0] rsp_rdata,
  output logic [63:0] Mem_Addr,
  output logic [63:0] WriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [63:0] ReadData
);

  // Every access covers addr..addr+7.
  localparam logic [63:0] ADDR_MAX =
    64'(MEM_BYTES) - 64'd8;

  lsu_state_e  state_q, state_d;
  logic [63:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [63:0] buf_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic [63:0] ext;
  logic [63:0] merged;

  assign accept  = (state_q == IDLE) && req_valid;
  assign req_err = f3_illegal(req_write, req_funct3)
                || (req_addr > ADDR_MAX);

  lsu_align u_align (
    .funct3_i (f3_q),
    .rdata_i  (ReadData),
    .wdata_i  (wdata_q),
    .ext_o    (ext),
    .merged_o (merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                   state_d = RESP;
          else if (!req_write)           state_d = LOAD;
          else if (req_funct3 == F3_D)   state_d = WRITE;
          else                           state_d = RMW_RD;
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Mem_Addr  = '0;
    WriteData = '0;
    unique case (1'b1)
      (state_q == LOAD),
      (state_q == RMW_RD): begin
        MemRead  = 1'b1;
        Mem_Addr = addr_q;
      end
      (state_q == WRITE): begin
        MemWrite  = 1'b1;
        Mem_Addr  = addr_q;
        WriteData = buf_q;
      end
      default: ;
    endcase
  end

  assign req_ready = reset_n && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        f3_q    <= req_funct3;
        wdata_q <= req_wdata[31:0];
        buf_q   <= req_wdata;
        err_q   <= req_err;
      end
      if (state_q == LOAD)   rdata_q <= ext;
      if (state_q == RMW_RD) buf_q   <= merged;
    end
  end

endmodule
